// File: rtl/shift_add_multiplier.sv
// Sequential 8x8 unsigned shift-and-add multiplier, one multiplier bit per clock.
// Each release of reset starts one multiplication; the product holds until the next reset.
module shift_add_multiplier (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  multiplicand,
  input  logic [7:0]  multiplier,
  output logic [15:0] result,
  output logic        end_op
);

  typedef enum logic [1:0] {
    LOAD = 2'b00,
    CALC = 2'b01,
    DONE = 2'b10
  } state_t;

  state_t      state;
  state_t      w_next;

  logic [15:0] r_acc;
  logic [15:0] r_mcand;
  logic [7:0]  r_mplier;
  logic [3:0]  r_cnt;
  logic [15:0] r_result;
  logic        r_end;

  logic [15:0] w_sum;
  logic        w_last;

  always_comb begin
    w_sum  = r_acc + (r_mplier[0] ? r_mcand : 16'd0);
    w_last = (r_cnt == 4'd7);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= LOAD;
    else      state <= w_next;
  end

  // The illegal encoding falls through to LOAD.
  always_comb begin
    w_next = LOAD;
    unique case (state)
      LOAD:    w_next = CALC;
      CALC:    w_next = w_last ? DONE : CALC;
      DONE:    w_next = DONE;
      default: w_next = LOAD;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_acc    <= 16'd0;
      r_mcand  <= 16'd0;
      r_mplier <= 8'd0;
      r_cnt    <= 4'd0;
      r_result <= 16'd0;
      r_end    <= 1'b0;
    end else begin
      unique case (state)
        LOAD: begin
          r_acc    <= 16'd0;
          r_mcand  <= {8'd0, multiplicand};
          r_mplier <= multiplier;
          r_cnt    <= 4'd0;
        end
        CALC: begin
          r_acc    <= w_sum;
          r_mcand  <= r_mcand << 1;
          r_mplier <= r_mplier >> 1;
          r_cnt    <= r_cnt + 4'd1;
          if (w_last) begin
            r_result <= w_sum;
            r_end    <= 1'b1;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign result = r_result;
  assign end_op = r_end;

endmodule

// File: tb/tb_shift_add_multiplier.sv
// Scoreboard bench for shift_add_multiplier: stimulus pushes a*b,
// a monitor pops on each end_op rise and tracks state/latency/hold.
module tb_shift_add_multiplier;

  logic        clk;
  logic        rst;
  logic [7:0]  multiplicand;
  logic [7:0]  multiplier;
  logic [15:0] result;
  logic        end_op;

  int n_checks = 0;
  int n_fail   = 0;
  int n_done   = 0;
  int cyc      = 0;
  int rel_cyc  = 0;

  logic [15:0] q[$];

  shift_add_multiplier dut (
    .clk          (clk),
    .rst          (rst),
    .multiplicand (multiplicand),
    .multiplier   (multiplier),
    .result       (result),
    .end_op       (end_op)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: samples 2 time units after each rising edge.
  initial begin
    logic        prev;
    logic [15:0] last;
    logic [15:0] exp_p;
    int          d;
    prev = 1'b0;
    last = 16'd0;
    forever begin
      @(posedge clk);
      #2;
      if (!rst) begin
        chk("rst_state", int'(dut.state), 0);
        chk("rst_result", int'(result), 0);
        chk("rst_end_op", int'(end_op), 0);
        prev = 1'b0;
      end else begin
        d = cyc - rel_cyc;
        chk("state_seq", int'(dut.state), (d >= 9) ? 2 : 1);
        chk("end_op_timing", int'(end_op), (d >= 9) ? 1 : 0);
        if (!prev && end_op) begin
          if (q.size() == 0) begin
            chk("unexpected_done", 1, 0);
          end else begin
            exp_p = q.pop_front();
            chk("product", int'(result), int'(exp_p));
          end
          chk("latency", d, 9);
          last = result;
          n_done++;
        end else if (prev && end_op) begin
          chk("hold_result", int'(result), int'(last));
        end else begin
          chk("no_partial", int'(result), 0);
        end
        prev = end_op;
      end
    end
  end

  // mode 0: fixed operands, 1: random operand churn, 2: switch to 7x7 in CALC
  task automatic run(input logic [7:0] a, input logic [7:0] b,
                     input int mode);
    int p;
    int base;
    rst = 1'b0;
    repeat (2) @(negedge clk);
    multiplicand = a;
    multiplier   = b;
    p = int'(a) * int'(b);
    q.push_back(p[15:0]);
    base    = n_done;
    rel_cyc = cyc;
    rst     = 1'b1;
    for (int i = 0; i < 200 && n_done == base; i++) begin
      @(negedge clk);
      if (mode == 1) begin
        multiplicand = 8'($urandom);
        multiplier   = 8'($urandom);
      end else if (mode == 2 && i == 3) begin
        multiplicand = 8'd7;
        multiplier   = 8'd7;
      end
    end
    chk("timeout", n_done - base, 1);
    repeat (4) @(negedge clk);
    @(posedge clk);
    #4 rst = 1'b0;
    #1;
    chk("async_clr_result", int'(result), 0);
    chk("async_clr_end_op", int'(end_op), 0);
  endtask

  task automatic abort_run(input logic [7:0] a, input logic [7:0] b,
                           input int n);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    multiplicand = a;
    multiplier   = b;
    rel_cyc = cyc;
    rst     = 1'b1;
    repeat (n) @(negedge clk);
    @(posedge clk);
    #4 rst = 1'b0;
    #1;
    chk("abort_state", int'(dut.state), 0);
    chk("abort_result", int'(result), 0);
    chk("abort_end_op", int'(end_op), 0);
  endtask

  initial begin
    rst          = 1'b0;
    multiplicand = 8'd0;
    multiplier   = 8'd0;
    #1;
    chk("reset_result", int'(result), 0);
    chk("reset_end_op", int'(end_op), 0);
    repeat (3) @(negedge clk);

    run(8'd3,   8'd5,   0);
    run(8'd10,  8'd12,  0);
    run(8'd13,  8'd11,  0);
    run(8'd127, 8'd201, 0);
    run(8'd255, 8'd255, 0);
    run(8'd0,   8'd123, 0);
    run(8'd123, 8'd0,   0);
    run(8'd3,   8'd5,   2);
    abort_run(8'd200, 8'd200, 4);
    run(8'd6,   8'd9,   0);
    for (int k = 0; k < 20; k++)
      run(8'($urandom), 8'($urandom), 1);

    chk("queue_empty", q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
